// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit.
// Holds FSM state encodings, opcodes, ALUOp/ALUControl codes and mux selects.
// Also provides the immediate-format decode, which depends only on the opcode.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format is a pure function of the opcode, independent of state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OP_SW:   sel = IMM_S;
            OP_BEQ:  sel = IMM_B;
            OP_JAL:  sel = IMM_J;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// master: controller side (drives enables/selects, reads instruction fields and zero).
// slave: datapath side (drives instruction fields and zero, reads controls).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [2:0] ALUControl;
    logic       illegal_op;

    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, illegal_op
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, illegal_op
    );
endinterface

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction fields to the 3-bit ALUControl.
// Ports: alu_op, funct3, op5 (opcode bit 5), funct7b5 in; alu_control out.
// Purely combinational, zero latency, no handshake.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) with funct7b5 subtracts; addi never does.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V datapath (lw/sw/R/I/beq/jal).
// Ports: clk, rst_n (async active-low), ctrl bundle (instruction fields in, controls out).
// One state per cycle; write enables are held low for as long as rst_n is low.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)(
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_controller_if.master   ctrl
);

    state_t     state;
    state_t     state_nxt;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] alu_op;
    logic [2:0] alu_control;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= state_t'(RESET_STATE);
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = S_FETCH;
        pc_update      = 1'b0;
        branch         = 1'b0;
        ir_write       = 1'b0;
        mem_write      = 1'b0;
        reg_write      = 1'b0;
        illegal        = 1'b0;
        alu_op         = ALUOP_ADD;
        ctrl.AdrSrc    = ADR_PC;
        ctrl.ResultSrc = RES_ALUOUT;
        ctrl.ALUSrcA   = SRCA_PC;
        ctrl.ALUSrcB   = SRCB_RS2;
        case (state)
            S_FETCH: begin
                ir_write       = 1'b1;
                pc_update      = 1'b1;
                ctrl.ALUSrcB   = SRCB_FOUR;
                ctrl.ResultSrc = RES_ALURESULT;
                state_nxt      = S_DECODE;
            end
            S_DECODE: begin
                ctrl.ALUSrcA = SRCA_OLDPC;
                ctrl.ALUSrcB = SRCB_IMM;
                if (ctrl.op == OP_LW || ctrl.op == OP_SW) begin
                    state_nxt = S_MEMADR;
                end else if (ctrl.op == OP_R) begin
                    state_nxt = S_EXECR;
                end else if (ctrl.op == OP_I) begin
                    state_nxt = S_EXECI;
                end else if (ctrl.op == OP_BEQ) begin
                    state_nxt = S_BEQ;
                end else if (ctrl.op == OP_JAL) begin
                    state_nxt = S_JAL;
                end else begin
                    illegal   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_MEMADR: begin
                ctrl.ALUSrcA = SRCA_RS1;
                ctrl.ALUSrcB = SRCB_IMM;
                state_nxt    = (ctrl.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctrl.AdrSrc = ADR_RESULT;
                state_nxt   = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.ResultSrc = RES_DATA;
                reg_write      = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.AdrSrc = ADR_RESULT;
                mem_write   = 1'b1;
            end
            S_EXECR: begin
                ctrl.ALUSrcA = SRCA_RS1;
                ctrl.ALUSrcB = SRCB_RS2;
                alu_op       = ALUOP_FUNCT;
                state_nxt    = S_ALUWB;
            end
            S_EXECI: begin
                ctrl.ALUSrcA = SRCA_RS1;
                ctrl.ALUSrcB = SRCB_IMM;
                alu_op       = ALUOP_FUNCT;
                state_nxt    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl.ALUSrcA = SRCA_RS1;
                ctrl.ALUSrcB = SRCB_RS2;
                alu_op       = ALUOP_SUB;
                branch       = 1'b1;
            end
            S_JAL: begin
                ctrl.ALUSrcA = SRCA_OLDPC;
                ctrl.ALUSrcB = SRCB_FOUR;
                pc_update    = 1'b1;
                state_nxt    = S_ALUWB;
            end
            // Unused encodings fall back to FETCH with every enable low.
            default: state_nxt = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (ctrl.funct3),
        .op5         (ctrl.op[5]),
        .funct7b5    (ctrl.funct7b5),
        .alu_control (alu_control)
    );

    // The state register already reads FETCH during reset, but FETCH itself
    // asserts PCWrite/IRWrite, so enables are also gated by rst_n directly.
    assign ctrl.PCWrite    = rst_n & (pc_update | (branch & ctrl.zero));
    assign ctrl.IRWrite    = rst_n & ir_write;
    assign ctrl.MemWrite   = rst_n & mem_write;
    assign ctrl.RegWrite   = rst_n & reg_write;
    assign ctrl.illegal_op = rst_n & illegal;
    assign ctrl.ImmSrc     = imm_src_of(ctrl.op);
    assign ctrl.ALUControl = alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed and random instructions,
// each cycle's full control vector compared with a per-instruction schedule model.
// Also exercises asynchronous reset asserted in the middle of a store.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Bits: PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[2], ALUSrcA[2],
    //       ALUSrcB[2], ImmSrc[2], RegWrite, ALUControl[3], illegal_op
    localparam logic [16:0] ENABLE_MASK = 17'b1_0_1_1_00_00_00_00_1_000_1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction class: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal.
    function automatic int klass(input logic [6:0] op);
        case (op)
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b0110011: return 2;
            7'b0010011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            default:    return 6;
        endcase
    endfunction

    function automatic int instr_len(input int k);
        case (k)
            0:       return 5;
            1, 2, 3, 5: return 4;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    // ALU operation for R/I execute, from the instruction's meaning.
    function automatic logic [2:0] alu_ref(input int k, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (k == 2 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected controls for cycle cyc (1-based) of an instruction.
    function automatic logic [16:0] expect_vec(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7, input logic z, input int cyc);
        int k;
        logic pcw, adr, memw, irw, rw, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] aluc;
        k = klass(op);
        pcw = 0; adr = 0; memw = 0; irw = 0; rw = 0; ill = 0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; aluc = 3'b000;
        imm = (k == 1) ? 2'b01 : (k == 4) ? 2'b10 : (k == 5) ? 2'b11 : 2'b00;
        if (cyc == 1) begin
            irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10;
        end else if (cyc == 2) begin
            sa = 2'b01; sb = 2'b01; ill = (k == 6);
        end else begin
            case (k)
                0, 1: begin
                    if (cyc == 3) begin sa = 2'b10; sb = 2'b01; end
                    else if (cyc == 4) begin adr = 1; memw = (k == 1); end
                    else begin rs = 2'b01; rw = 1; end
                end
                2, 3: begin
                    if (cyc == 3) begin
                        sa = 2'b10; sb = (k == 2) ? 2'b00 : 2'b01; aluc = alu_ref(k, f3, f7);
                    end else rw = 1;
                end
                4: begin sa = 2'b10; aluc = 3'b001; pcw = z; end
                5: begin
                    if (cyc == 3) begin sa = 2'b01; sb = 2'b10; pcw = 1; end
                    else rw = 1;
                end
                default: ;
            endcase
        end
        return {pcw, adr, memw, irw, rs, sa, sb, imm, rw, aluc, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite, bus.ALUControl,
                bus.illegal_op};
    endfunction

    // Runs an instruction from FETCH; ncyc > 0 stops early after that many cycles.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input bit rand_zero, input logic zfix, input int ncyc);
        int len;
        len = instr_len(klass(op));
        if (ncyc > 0) len = ncyc;
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
        for (int c = 1; c <= len; c++) begin
            bus.zero = rand_zero ? 1'($urandom_range(0, 1)) : zfix;
            @(negedge clk);
            check_eq($sformatf("%s_c%0d", name, c), 32'(observed()),
                     32'(expect_vec(op, f3, f7, bus.zero, c)));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] rop;
        logic [6:0] legal [6];
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

        rst_n = 1'b0;
        bus.op = 7'b0000011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b1;
        #2;
        check_eq("reset_vec0", 32'(observed()),
                 32'(expect_vec(bus.op, 3'b000, 1'b0, 1'b1, 1) & ~ENABLE_MASK));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_vec1", 32'(observed()),
                 32'(expect_vec(bus.op, 3'b000, 1'b0, 1'b1, 1) & ~ENABLE_MASK));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases
        run_instr("lw",       7'b0000011, 3'b010, 1'b0, 0, 1'b0, 0);
        run_instr("sw",       7'b0100011, 3'b010, 1'b1, 0, 1'b0, 0);
        run_instr("r_sub",    7'b0110011, 3'b000, 1'b1, 0, 1'b0, 0);
        run_instr("r_add",    7'b0110011, 3'b000, 1'b0, 0, 1'b0, 0);
        run_instr("i_addi_f7",7'b0010011, 3'b000, 1'b1, 0, 1'b0, 0);
        run_instr("r_slt",    7'b0110011, 3'b010, 1'b0, 0, 1'b0, 0);
        run_instr("r_or",     7'b0110011, 3'b110, 1'b0, 0, 1'b0, 0);
        run_instr("r_and",    7'b0110011, 3'b111, 1'b0, 0, 1'b0, 0);
        run_instr("beq_taken",7'b1100011, 3'b000, 1'b0, 0, 1'b1, 0);
        run_instr("beq_not",  7'b1100011, 3'b000, 1'b0, 0, 1'b0, 0);
        run_instr("jal",      7'b1101111, 3'b000, 1'b0, 0, 1'b0, 0);
        run_instr("illegal",  7'b1111111, 3'b000, 1'b0, 0, 1'b0, 0);
        run_instr("after_ill",7'b0010011, 3'b111, 1'b0, 0, 1'b0, 0);

        // Reset asserted mid-store: MemWrite must drop without a clock edge.
        run_instr("sw_rst", 7'b0100011, 3'b010, 1'b0, 0, 1'b0, 3);
        @(negedge clk);
        check_eq("sw_rst_c4", 32'(observed()), 32'(expect_vec(bus.op, 3'b010, 1'b0, bus.zero, 4)));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check_eq("rst_mid_vec", 32'(observed()),
                 32'(expect_vec(bus.op, 3'b010, 1'b0, bus.zero, 1) & ~ENABLE_MASK));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr("post_rst_lw", 7'b0000011, 3'b010, 1'b0, 0, 1'b0, 0);

        // Random instruction stream
        for (int i = 0; i < 80; i++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            if (sel < 6) rop = legal[sel];
            else if (sel == 6) rop = 7'b1111111;
            else rop = 7'($urandom_range(0, 127));
            run_instr($sformatf("rnd%0d", i), rop, 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle RISC-V datapath, built around the existing ALU.
- Produces the ALU's 3-bit ALUControl and consumes its Zero flag, so it sits at the other end of the ALU control interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback with a Moore FSM.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  7  opcode field of the instruction register.
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- zero  input  1  Zero flag from the ALU.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut/Result.
- MemWrite  output  1  data memory write enable.
- IRWrite  output  1  instruction/OldPC register enable.
- ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  ALU B operand: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  output  1  register file write enable.
- ALUControl  output  3  ALU operation code.
- illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous active-low on rst_n: state goes to FETCH immediately when rst_n falls.
- Outputs during reset: while rst_n = 0, PCWrite, IRWrite, MemWrite, RegWrite and illegal_op are forced to 0. All other outputs take their FETCH values.
- Output decode: state is registered. Outputs decode combinationally from state, except:
  - PCWrite = PCUpdate | (Branch & zero).
  - ImmSrc and ALUControl also depend on op, funct3 and funct7b5.
- Internal 2-bit ALUOp feeds the ALU decoder. Any output not listed in a state below is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - otherwise -> FETCH with illegal_op=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- Latency in cycles: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4, illegal 2.
- ALU decoder:
  - ALUOp 00 -> 000 (add). ALUOp 01 -> 001 (sub). ALUOp 11 -> 000.
  - ALUOp 10 by funct3: 000 -> 001 if (op[5] & funct7b5), else 000; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
- ImmSrc: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; all other opcodes -> 00.
- Unused state encodings: next state is FETCH and all enables are 0.
- Reset mid-instruction: no write enable may assert after rst_n falls. The first cycle after rst_n rises is FETCH.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encodings (4-bit);
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - ALUControl codes (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101);
  - ALUOp codes;
  - mux select constants.
- One sub-module: alu_decoder, combinational (ALUOp, funct3, op[5], funct7b5 -> ALUControl).
- The FSM and ImmSrc decode stay in multicycle_controller.

Test Plan:
- lw (op=0000011), reset released -> state path FETCH, DECODE, MEMADR, MEMREAD, MEMWB. IRWrite=1 in cycle 1 only; ALUSrcA=10 and ALUSrcB=01 in cycle 3; RegWrite=1 and ResultSrc=01 in cycle 5; next cycle IRWrite=1.
- sw (op=0100011) -> MemWrite=1 in cycle 4 only, AdrSrc=1, ImmSrc=01, RegWrite never 1.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR. Same with funct7b5=0 -> 000. I-type with funct7b5=1 -> 000. funct3=010 -> 101; 110 -> 011; 111 -> 010.
- beq (op=1100011): zero=1 -> PCWrite=1 in cycle 3, ALUControl=001, ImmSrc=10. zero=0 -> PCWrite=0 in cycle 3.
- jal (op=1101111) -> PCWrite=1 in cycle 3, RegWrite=1 in cycle 4, ImmSrc=11. Unsupported op=1111111 -> illegal_op=1 in cycle 2, FETCH in cycle 3.
- rst_n dropped during MEMWRITE -> MemWrite falls to 0 immediately with no clock edge. After release, first cycle is FETCH with IRWrite=1.
